case_3_acc_8s_16s: RTL and testbench
====================================

// Module: case_3_acc_8s_16s
// PURPOSE
//  Downstream consumer of the case_3 4s x 4s -> 8s multiplier.
//  Accumulates a stream of signed 8-bit products into a signed 16-bit sum, one packet per result. Packets are delimited by prod_tlast.
//  Sits between the multiplier output and the case_3 result writer.
//  Valid/ready on both sides; one registered result slot on the output.
// PARAMETERS
//  ID          1   instance tag; no functional effect
//  din_WIDTH   8   product width, signed
//  dout_WIDTH  16  accumulator/result width, signed; must be >= din_WIDTH
//  CNT_WIDTH   10  term counter width
// PORTS
//  ap_clk        in   1          clock; all logic on rising edge
//  ap_rst        in   1          synchronous reset, active-high
//  prod_tdata    in   din_WIDTH  signed product from multiplier
//  prod_tvalid   in   1          product beat valid
//  prod_tlast    in   1          last product of packet
//  prod_tready   out  1          block accepts beat this cycle
//  sum_tdata     out  dout_WIDTH signed packet sum
//  sum_tcnt      out  CNT_WIDTH  number of terms in packet, mod 2^CNT_WIDTH
//  sum_tsat      out  1          saturation occurred in packet (0 if CASE3_ACC_SAT_EN undefined)
//  sum_tvalid    out  1          result valid; held until sum_tready
//  sum_tready    in   1          downstream accepts result
// BEHAVIOUR
//  Reset: ap_rst high at an edge -> state IDLE, acc=0, cnt=0, sat=0, sum_tvalid=0, sum_tdata=0, sum_tcnt=0, sum_tsat=0. A partial packet is discarded; a pending result is dropped.
//  Beat accepted iff prod_tvalid & prod_tready.
//  prod_tready = !sum_tvalid | sum_tready (combinational). No other stall source.
//  FSM: IDLE (no open packet) / ACC (packet open).
//   IDLE + beat, !tlast -> ACC; acc=sext(d), cnt=1.
//   IDLE + beat, tlast  -> IDLE; result=sext(d), cnt=1.
//   ACC + beat, !tlast  -> ACC; acc+=sext(d), cnt+=1.
//   ACC + beat, tlast   -> IDLE; result=acc+sext(d), cnt+1.
//   No beat -> state, acc and cnt hold.
//  Result load: on a tlast beat, sum_tdata/sum_tcnt/sum_tsat load and sum_tvalid=1 on the next edge.
//   Latency tlast-accept -> sum_tvalid is 1 cycle.
//  Result clear: sum_tvalid & sum_tready with no tlast beat -> sum_tvalid=0 next edge.
//   If a tlast beat is accepted in the same cycle, sum_tvalid stays 1 and new data loads: back-to-back results, no bubble.
//  Output fields are stable while sum_tvalid & !sum_tready.
//  Arithmetic: sign-extend din to dout_WIDTH+1 bits, add, then apply the overflow rule below.
//  sum_tcnt wraps modulo 2^CNT_WIDTH; no error flag.
// CONFIGURATION
//  CASE3_ACC_SAT_EN defined:
//   - each add clamps to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
//   - sat flag is sticky per packet and cleared at packet start; it is reported on sum_tsat.
//  CASE3_ACC_SAT_EN undefined:
//   - two's-complement wrap modulo 2^dout_WIDTH.
//   - sum_tsat is tied to 0 and no sat register is built.
// STRUCTURE
//  Package case_3_acc_pkg:
//   - state enum {ST_IDLE, ST_ACC};
//   - default width localparams;
//   - sat_add function (dout_WIDTH+1 -> dout_WIDTH clamp).
//  Sub-module case_3_acc_out_slice:
//   - holds the result register plus the valid/ready logic;
//   - receives load strobe and data;
//   - drives sum_* and prod_tready.
//  Top: FSM, accumulator, counter, sat flag.
// TESTING
//  1. Beats 0x31, 0xF0, 0x07(tlast), sum_tready=1 -> one result 0x0028 (+40), cnt=3, tsat=0, one cycle after tlast.
//  2. Single beat 0x80 with tlast -> 0xFF80 (-128), cnt=1. Then an immediate next packet 0x01(tlast) -> 0x0001 on the following cycle, no bubble.
//  3. 700 beats of 0x7F, last one tlast:
//     - with SAT_EN -> 0x7FFF, tsat=1, cnt=700;
//     - without -> 0x5B44, tsat=0, cnt=700.
//  4. Result pending, sum_tready=0 for 5 cycles -> prod_tready=0 and sum_* stable. Raise sum_tready -> one transfer, prod_tready=1 the same cycle.
//  5. ap_rst pulsed after 2 beats of a packet -> all outputs 0. Next packet 0x02, 0x03(tlast) -> 0x0005, cnt=2; old partial sum not included.

Source files
------------

// File: rtl/case_3_acc_pkg.sv
// Shared definitions for the case_3 product accumulator.
//   - state_t   : packet FSM states (no open packet / packet open)
//   - DIN_W, DOUT_W, CNT_W : default widths for the 8s -> 16s instance
//   - SAT_MAX_W : widest accumulator that sat_add can clamp
//   - sat_add   : clamps a (w+1)-bit signed sum to the signed w-bit range
package case_3_acc_pkg;

  localparam int DIN_W     = 8;
  localparam int DOUT_W    = 16;
  localparam int CNT_W     = 10;
  localparam int SAT_MAX_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // The sum arrives sign-extended to SAT_MAX_W+1 bits so one function serves
  // any accumulator width w < SAT_MAX_W. The clamped value is returned
  // sign-extended to SAT_MAX_W bits; the caller keeps the low w bits.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W:0] sum,
    input int unsigned               w
  );
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    hi = $signed(((SAT_MAX_W+1)'(1) << (w - 1)) - (SAT_MAX_W+1)'(1));
    lo = ~hi;  // -2^(w-1) == ~(2^(w-1)-1)
    if (sum > hi)      sat_add = hi[SAT_MAX_W-1:0];
    else if (sum < lo) sat_add = lo[SAT_MAX_W-1:0];
    else               sat_add = sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/case_3_acc_out_slice.sv
// Registered result slot for the case_3 accumulator.
// Holds one packet result and implements the valid/ready handshake on the
// sum side. A load and a downstream accept in the same cycle replace the
// result without a bubble.
// Optional feature: CASE3_ACC_SAT_EN adds the saturation-flag register;
// without it sum_tsat is a constant 0.
// Ports:
//   ap_clk, ap_rst      clock, synchronous active-high reset
//   load                a tlast beat is accepted this cycle
//   ld_data/ld_cnt      result sum and term count to load
//   ld_sat              packet saturated (CASE3_ACC_SAT_EN only)
//   sum_tdata/tcnt/tsat registered result fields
//   sum_tvalid/tready   result handshake
//   prod_tready         upstream may transfer a beat this cycle
module case_3_acc_out_slice
  import case_3_acc_pkg::*;
#(
  parameter int dout_WIDTH = DOUT_W,
  parameter int CNT_WIDTH  = CNT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  load,
  input  logic [dout_WIDTH-1:0] ld_data,
  input  logic [CNT_WIDTH-1:0]  ld_cnt,
`ifdef CASE3_ACC_SAT_EN
  input  logic                  ld_sat,
`endif
  output logic [dout_WIDTH-1:0] sum_tdata,
  output logic [CNT_WIDTH-1:0]  sum_tcnt,
  output logic                  sum_tsat,
  output logic                  sum_tvalid,
  input  logic                  sum_tready,
  output logic                  prod_tready
);

  // The slot is free when empty or being drained this cycle.
  assign prod_tready = !sum_tvalid | sum_tready;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sum_tvalid <= 1'b0;
      sum_tdata  <= '0;
      sum_tcnt   <= '0;
    end else if (load) begin
      sum_tvalid <= 1'b1;
      sum_tdata  <= ld_data;
      sum_tcnt   <= ld_cnt;
    end else if (sum_tready) begin
      sum_tvalid <= 1'b0;
    end
  end

`ifdef CASE3_ACC_SAT_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst)    sum_tsat <= 1'b0;
    else if (load) sum_tsat <= ld_sat;
  end
`else
  assign sum_tsat = 1'b0;
`endif

endmodule

// File: rtl/case_3_acc_8s_16s.sv
// Packet accumulator behind the case_3 4s x 4s -> 8s multiplier.
// Sums a stream of signed products into one signed result per packet
// (packets end on prod_tlast) and hands it to the result writer through a
// single registered slot.
// Optional feature: define CASE3_ACC_SAT_EN to clamp every add to the signed
// dout_WIDTH range and report a sticky per-packet flag on sum_tsat; when
// undefined the sum wraps modulo 2^dout_WIDTH and sum_tsat is 0.
// Ports:
//   ap_clk, ap_rst                  clock, synchronous active-high reset
//   prod_tdata/tvalid/tlast/tready  product stream in
//   sum_tdata/tcnt/tsat             packet sum, term count, saturation flag
//   sum_tvalid/tready               result handshake out
module case_3_acc_8s_16s
  import case_3_acc_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din_WIDTH  = DIN_W,
  parameter int dout_WIDTH = DOUT_W,
  parameter int CNT_WIDTH  = CNT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [din_WIDTH-1:0]  prod_tdata,
  input  logic                  prod_tvalid,
  input  logic                  prod_tlast,
  output logic                  prod_tready,
  output logic [dout_WIDTH-1:0] sum_tdata,
  output logic [CNT_WIDTH-1:0]  sum_tcnt,
  output logic                  sum_tsat,
  output logic                  sum_tvalid,
  input  logic                  sum_tready
);

  // ID is only a tag; it is referenced here so it stays visible in the
  // elaborated design.
  if (din_WIDTH > dout_WIDTH || dout_WIDTH >= SAT_MAX_W || ID < 0) begin : g_bad_cfg
    $error("case_3_acc_8s_16s: illegal widths or ID");
  end

  state_t                        state;
  state_t                        state_next;
  logic signed [dout_WIDTH-1:0]  acc;
  logic signed [dout_WIDTH-1:0]  d_ext;
  logic signed [dout_WIDTH-1:0]  base;
  logic signed [dout_WIDTH-1:0]  add_val;
  logic [CNT_WIDTH-1:0]          cnt;
  logic [CNT_WIDTH-1:0]          cnt_next;
  logic                          beat;
  logic                          load;
`ifdef CASE3_ACC_SAT_EN
  logic signed [dout_WIDTH:0]    wide_sum;
  logic signed [SAT_MAX_W-1:0]   clamped;
  logic                          sat;
  logic                          sat_next;
`endif

  assign beat  = prod_tvalid & prod_tready;
  assign load  = beat & prod_tlast;
  assign d_ext = dout_WIDTH'($signed(prod_tdata));

  // ---- FSM: state register ----
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  // ---- FSM: next state ----
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (beat) state_next = prod_tlast ? ST_IDLE : ST_ACC;
  end

  // ---- FSM: datapath outputs ----
  // In IDLE the running sum and count start from zero, so the first beat of
  // a packet overwrites whatever the previous packet left behind.
  always_comb begin
    base     = (state == ST_ACC) ? acc : '0;
    cnt_next = ((state == ST_ACC) ? cnt : '0) + CNT_WIDTH'(1);
`ifdef CASE3_ACC_SAT_EN
    // One extra bit holds the true sum; any clamp shows up as a difference
    // between the clamped and the true value.
    wide_sum = (dout_WIDTH+1)'(base) + (dout_WIDTH+1)'(d_ext);
    clamped  = sat_add((SAT_MAX_W+1)'(wide_sum), dout_WIDTH);
    add_val  = clamped[dout_WIDTH-1:0];
    sat_next = ((state == ST_ACC) ? sat : 1'b0) | (clamped != SAT_MAX_W'(wide_sum));
`else
    add_val  = base + d_ext;
`endif
  end

  // Accumulator, term counter and sat flag advance only on accepted beats.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (beat) begin
      acc <= add_val;
      cnt <= cnt_next;
    end
  end

`ifdef CASE3_ACC_SAT_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst)    sat <= 1'b0;
    else if (beat) sat <= sat_next;
  end
`endif

  // The result slot loads the value including the tlast beat itself.
  case_3_acc_out_slice #(
    .dout_WIDTH (dout_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_out (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .load        (load),
    .ld_data     (add_val),
    .ld_cnt      (cnt_next),
`ifdef CASE3_ACC_SAT_EN
    .ld_sat      (sat_next),
`endif
    .sum_tdata   (sum_tdata),
    .sum_tcnt    (sum_tcnt),
    .sum_tsat    (sum_tsat),
    .sum_tvalid  (sum_tvalid),
    .sum_tready  (sum_tready),
    .prod_tready (prod_tready)
  );

endmodule

// File: tb/tb_case_3_acc_8s_16s.sv
// Self-checking bench for case_3_acc_8s_16s (default widths 8s -> 16s).
// Expected values for the long saturating packet follow CASE3_ACC_SAT_EN.
module tb_case_3_acc_8s_16s;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [7:0]  prod_tdata;
  logic        prod_tvalid;
  logic        prod_tlast;
  logic        prod_tready;
  logic [15:0] sum_tdata;
  logic [9:0]  sum_tcnt;
  logic        sum_tsat;
  logic        sum_tvalid;
  logic        sum_tready;

  int errors = 0;
  int checks = 0;

`ifdef CASE3_ACC_SAT_EN
  localparam logic [15:0] EXP_LONG_DATA = 16'h7FFF;
  localparam logic        EXP_LONG_SAT  = 1'b1;
`else
  localparam logic [15:0] EXP_LONG_DATA = 16'h5B44;
  localparam logic        EXP_LONG_SAT  = 1'b0;
`endif

  case_3_acc_8s_16s #(.ID(1)) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .prod_tdata  (prod_tdata),
    .prod_tvalid (prod_tvalid),
    .prod_tlast  (prod_tlast),
    .prod_tready (prod_tready),
    .sum_tdata   (sum_tdata),
    .sum_tcnt    (sum_tcnt),
    .sum_tsat    (sum_tsat),
    .sum_tvalid  (sum_tvalid),
    .sum_tready  (sum_tready)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    prod_tvalid = 1'b1;
    prod_tdata  = d;
    prod_tlast  = last;
    tick();
    prod_tvalid = 1'b0;
  endtask

  typedef struct {
    logic        vld;
    logic [7:0]  d;
    logic        last;
    logic        ev;   // expected sum_tvalid after the edge
    logic [15:0] ed;   // expected sum_tdata
    logic [9:0]  ec;   // expected sum_tcnt
  } vec_t;

  vec_t vecs[10];

  initial begin
    // beat in                    -> result after the edge
    vecs[0] = '{1'b1, 8'h31, 1'b0, 1'b0, 16'h0000, 10'd0};
    vecs[1] = '{1'b1, 8'hF0, 1'b0, 1'b0, 16'h0000, 10'd0};
    vecs[2] = '{1'b1, 8'h07, 1'b1, 1'b1, 16'h0028, 10'd3};  // 49-16+7
    vecs[3] = '{1'b1, 8'h80, 1'b1, 1'b1, 16'hFF80, 10'd1};  // -128 alone
    vecs[4] = '{1'b1, 8'h01, 1'b1, 1'b1, 16'h0001, 10'd1};  // no bubble
    vecs[5] = '{1'b0, 8'h55, 1'b1, 1'b0, 16'h0001, 10'd1};  // idle: drained, held
    vecs[6] = '{1'b1, 8'hFF, 1'b0, 1'b0, 16'h0001, 10'd1};
    vecs[7] = '{1'b1, 8'hFE, 1'b1, 1'b1, 16'hFFFD, 10'd2};  // -1 + -2
    vecs[8] = '{1'b1, 8'h7F, 1'b1, 1'b1, 16'h007F, 10'd1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h007F, 10'd1};

    ap_rst      = 1'b1;
    prod_tvalid = 1'b0;
    prod_tdata  = '0;
    prod_tlast  = 1'b0;
    sum_tready  = 1'b1;
    tick();
    tick();
    ap_rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(sum_tvalid), 32'd0);
    check("rst_data",  32'(sum_tdata),  32'd0);
    check("rst_cnt",   32'(sum_tcnt),   32'd0);
    check("rst_sat",   32'(sum_tsat),   32'd0);
    check("rst_ready", 32'(prod_tready), 32'd1);

    // Directed vectors, downstream always ready
    for (int i = 0; i < 10; i++) begin
      prod_tvalid = vecs[i].vld;
      prod_tdata  = vecs[i].d;
      prod_tlast  = vecs[i].last;
      check($sformatf("vec%0d_ready", i), 32'(prod_tready), 32'd1);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(sum_tvalid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_data", i),  32'(sum_tdata),  32'(vecs[i].ed));
      check($sformatf("vec%0d_cnt", i),   32'(sum_tcnt),   32'(vecs[i].ec));
      check($sformatf("vec%0d_sat", i),   32'(sum_tsat),   32'd0);
    end
    prod_tvalid = 1'b0;

    // Long packet: 700 x 0x7F
    for (int i = 0; i < 700; i++) begin
      prod_tvalid = 1'b1;
      prod_tdata  = 8'h7F;
      prod_tlast  = (i == 699);
      tick();
      if (i == 698) check("long_midvalid", 32'(sum_tvalid), 32'd0);
    end
    prod_tvalid = 1'b0;
    check("long_valid", 32'(sum_tvalid), 32'd1);
    check("long_data",  32'(sum_tdata),  32'(EXP_LONG_DATA));
    check("long_cnt",   32'(sum_tcnt),   32'd700);
    check("long_sat",   32'(sum_tsat),   32'(EXP_LONG_SAT));
    tick();
    check("long_drain", 32'(sum_tvalid), 32'd0);

    // Backpressure: result held while sum_tready is low, upstream stalled
    sum_tready = 1'b0;
    send(8'h05, 1'b1);
    prod_tvalid = 1'b1;  // offered beat must not be taken while stalled
    prod_tdata  = 8'h10;
    prod_tlast  = 1'b1;
    check("bp_valid", 32'(sum_tvalid), 32'd1);
    check("bp_data",  32'(sum_tdata),  32'h0005);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_ready", k), 32'(prod_tready), 32'd0);
      tick();
      check($sformatf("bp%0d_valid", k), 32'(sum_tvalid), 32'd1);
      check($sformatf("bp%0d_data", k),  32'(sum_tdata),  32'h0005);
      check($sformatf("bp%0d_cnt", k),   32'(sum_tcnt),   32'd1);
    end
    prod_tvalid = 1'b0;
    sum_tready  = 1'b1;
    #1;
    check("bp_release_ready", 32'(prod_tready), 32'd1);
    tick();
    check("bp_after_valid", 32'(sum_tvalid), 32'd0);
    check("bp_after_data",  32'(sum_tdata),  32'h0005);
    send(8'h10, 1'b1);
    check("bp_next_data", 32'(sum_tdata), 32'h0010);
    check("bp_next_cnt",  32'(sum_tcnt),  32'd1);

    // Reset in the middle of a packet discards the partial sum
    send(8'h40, 1'b0);
    send(8'h40, 1'b0);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check("mrst_valid", 32'(sum_tvalid), 32'd0);
    check("mrst_data",  32'(sum_tdata),  32'd0);
    check("mrst_cnt",   32'(sum_tcnt),   32'd0);
    check("mrst_sat",   32'(sum_tsat),   32'd0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    check("mrst_pkt_valid", 32'(sum_tvalid), 32'd1);
    check("mrst_pkt_data",  32'(sum_tdata),  32'h0005);
    check("mrst_pkt_cnt",   32'(sum_tcnt),   32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
